mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back select for the 32-bit MIPS pipeline.
- Captures the memory-stage results (DataMemory read data, ALU result, link address, control) on each clock.
- Drives the register-file write port and the WB-to-EX forwarding path.
- Supports stall and flush, and keeps a retired-instruction counter.

Parameters:
- NBits, 32, datapath width.
- NRegBits, 5, register-index width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Stall  input  1  hold all pipeline registers.
- Flush  input  1  insert a bubble into WB.
- Valid_MEM  input  1  the MEM-stage slot holds a real instruction.
- RegWrite_MEM  input  1  the instruction writes the register file.
- MemtoReg_MEM  input  1  select memory data for write-back.
- Jal_MEM  input  1  select the link address for write-back.
- WriteRegister_MEM  input  NRegBits  destination register index.
- ALUResult_MEM  input  NBits  ALU result from the MEM stage.
- MemoryData_MEM  input  NBits  DataMemory read data, combinationally valid in MEM.
- PCPlus4_MEM  input  NBits  link address.
- Valid_WB  output  1  the WB slot holds a real instruction.
- RegWrite_WB  output  1  register-file write enable.
- WriteRegister_WB  output  NRegBits  register-file write index.
- WriteData_WB  output  NBits  register-file write data / forwarding value.
- RetiredCount  output  32  number of instructions retired.

Behaviour:
- Reset (reset=0, asynchronous): Valid_WB=0, RegWrite_WB=0, WriteRegister_WB=0, WriteData_WB=0, RetiredCount=0.
  - Takes effect immediately, mid-stall or mid-flush included.
  - Release is synchronous to the next rising edge.
- Latency is one cycle: MEM inputs present before rising edge N appear on the WB outputs after edge N.
- Write-back select is resolved before the register and stored in the WB data register:
  - Jal_MEM=1: PCPlus4_MEM (Jal has priority over MemtoReg).
  - else MemtoReg_MEM=1: MemoryData_MEM.
  - else: ALUResult_MEM.
- Captured write enable is RegWrite_MEM & Valid_MEM & (WriteRegister_MEM != 0). Register $zero is never written.
- Priority per edge is Flush > Stall > normal capture:
  - Flush=1: Valid_WB<=0 and RegWrite_WB<=0. WriteRegister_WB and WriteData_WB are loaded with 0.
  - Stall=1 (Flush=0): all WB registers hold their values, and RegWrite_WB keeps its value. Rewriting the same value into the register file is harmless.
  - Otherwise: capture the MEM inputs.
- Outputs are pure register outputs with no combinational input-to-output path.
- RetiredCount increments by 1 on a rising edge where Valid_WB=1 and Stall=0 and Flush=0, i.e. the WB instruction leaves.
  - A flushed or stalled edge does not count.
  - The counter wraps 0xFFFF_FFFF -> 0x0000_0000 with no flag.
- Valid_MEM=0 with RegWrite_MEM=1 produces a bubble: Valid_WB=0, RegWrite_WB=0, and the data is still captured (don't-care).
- All fields are NBits wide. There is no sign or zero extension and no arithmetic apart from the counter.

Test Plan:
- Reset mid-operation: run 3 valid instructions, then assert reset=0 between edges -> all outputs 0 immediately, RetiredCount=0. The first capture after release loads correctly.
- Load path: Valid=1, RegWrite=1, MemtoReg=1, WriteRegister=8, MemoryData=0x1234_5678, ALUResult=0x1001_0004 -> next cycle RegWrite_WB=1, WriteRegister_WB=8, WriteData_WB=0x1234_5678.
- Jal over MemtoReg: Jal=1, MemtoReg=1, PCPlus4=0x0040_0010, WriteRegister=31 -> WriteData_WB=0x0040_0010, WriteRegister_WB=31.
- $zero guard: RegWrite=1, WriteRegister=0, ALUResult=0xDEAD_BEEF -> RegWrite_WB=0, Valid_WB=1. RetiredCount increments on the following non-stalled edge.
- Stall/flush priority:
  - Hold Stall=1 for 3 cycles with changing inputs -> WB outputs unchanged, RetiredCount unchanged.
  - Assert Stall=1 and Flush=1 together -> Valid_WB=0, RegWrite_WB=0.
- Counter wrap: force a run of 2^32 retirements, or preload via hierarchical deposit to 0xFFFF_FFFE, then retire 3 instructions -> RetiredCount=0x0000_0001.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the 32-bit MIPS pipeline.
// Resolves the write-back source before the register, guards $zero writes,
// supports stall/flush, and counts instructions leaving the WB stage.
module mem_wb_stage #(
    parameter int unsigned NBits    = 32,
    parameter int unsigned NRegBits = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic                Valid_MEM,
    input  logic                RegWrite_MEM,
    input  logic                MemtoReg_MEM,
    input  logic                Jal_MEM,
    input  logic [NRegBits-1:0] WriteRegister_MEM,
    input  logic [NBits-1:0]    ALUResult_MEM,
    input  logic [NBits-1:0]    MemoryData_MEM,
    input  logic [NBits-1:0]    PCPlus4_MEM,
    output logic                Valid_WB,
    output logic                RegWrite_WB,
    output logic [NRegBits-1:0] WriteRegister_WB,
    output logic [NBits-1:0]    WriteData_WB,
    output logic [31:0]         RetiredCount
);

    logic                valid_q,    valid_d;
    logic                regwrite_q, regwrite_d;
    logic [NRegBits-1:0] wreg_q,     wreg_d;
    logic [NBits-1:0]    wdata_q,    wdata_d;
    logic [31:0]         retired_q,  retired_d;
    logic [NBits-1:0]    wb_sel;
    logic                wr_en_mem;

    // Write-back source select: link address beats memory data beats ALU result.
    always_comb begin
        wb_sel = ALUResult_MEM;
        if (Jal_MEM) begin
            wb_sel = PCPlus4_MEM;
        end else if (MemtoReg_MEM) begin
            wb_sel = MemoryData_MEM;
        end
    end

    // Write enable only for a real instruction that does not target $zero.
    always_comb begin
        wr_en_mem = RegWrite_MEM & Valid_MEM & (WriteRegister_MEM != '0);
    end

    // Next-state for the WB slot: flush clears, stall holds, otherwise capture.
    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (Flush) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            wreg_d     = '0;
            wdata_d    = '0;
        end else if (!Stall) begin
            valid_d    = Valid_MEM;
            regwrite_d = wr_en_mem;
            wreg_d     = WriteRegister_MEM;
            wdata_d    = wb_sel;
        end
    end

    // Retire counter: counts the WB instruction leaving on an unstalled, unflushed edge.
    always_comb begin
        retired_d = retired_q;
        if (valid_q && !Stall && !Flush) begin
            retired_d = retired_q + 32'd1;
        end
    end

    // WB pipeline registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    // Retired-instruction counter register; wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign Valid_WB         = valid_q;
    assign RegWrite_WB      = regwrite_q;
    assign WriteRegister_WB = wreg_q;
    assign WriteData_WB     = wdata_q;
    assign RetiredCount     = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random traffic against a
// behavioural model of the WB slot and retire counter.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall, Flush;
    logic        Valid_MEM, RegWrite_MEM, MemtoReg_MEM, Jal_MEM;
    logic [4:0]  WriteRegister_MEM;
    logic [31:0] ALUResult_MEM, MemoryData_MEM, PCPlus4_MEM;
    logic        Valid_WB, RegWrite_WB;
    logic [4:0]  WriteRegister_WB;
    logic [31:0] WriteData_WB;
    logic [31:0] RetiredCount;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic        m_valid, m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd, m_cnt;
    logic [31:0] saved_cnt;

    mem_wb_stage #(.NBits(32), .NRegBits(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Flush             (Flush),
        .Valid_MEM         (Valid_MEM),
        .RegWrite_MEM      (RegWrite_MEM),
        .MemtoReg_MEM      (MemtoReg_MEM),
        .Jal_MEM           (Jal_MEM),
        .WriteRegister_MEM (WriteRegister_MEM),
        .ALUResult_MEM     (ALUResult_MEM),
        .MemoryData_MEM    (MemoryData_MEM),
        .PCPlus4_MEM       (PCPlus4_MEM),
        .Valid_WB          (Valid_WB),
        .RegWrite_WB       (RegWrite_WB),
        .WriteRegister_WB  (WriteRegister_WB),
        .WriteData_WB      (WriteData_WB),
        .RetiredCount      (RetiredCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, {31'd0, Valid_WB}, {31'd0, m_valid});
        check({tag, ".rw"},    {31'd0, RegWrite_WB}, {31'd0, m_rw});
        check({tag, ".wr"},    {27'd0, WriteRegister_WB}, {27'd0, m_wr});
        check({tag, ".wd"},    WriteData_WB, m_wd);
        check({tag, ".cnt"},   RetiredCount, m_cnt);
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0; m_cnt = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held across it.
    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            if (m_valid && !Stall && !Flush) m_cnt = m_cnt + 32'd1;
            if (Flush) begin
                m_valid = 1'b0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
            end else if (!Stall) begin
                m_valid = Valid_MEM;
                m_rw    = RegWrite_MEM && Valid_MEM && (WriteRegister_MEM != 5'd0);
                m_wr    = WriteRegister_MEM;
                m_wd    = Jal_MEM ? PCPlus4_MEM : (MemtoReg_MEM ? MemoryData_MEM : ALUResult_MEM);
            end
        end
    endtask

    task automatic set_in(input logic v, input logic rw, input logic mtr, input logic jal,
                          input logic [4:0] wr, input logic [31:0] alu,
                          input logic [31:0] md, input logic [31:0] pc);
        Valid_MEM = v; RegWrite_MEM = rw; MemtoReg_MEM = mtr; Jal_MEM = jal;
        WriteRegister_MEM = wr; ALUResult_MEM = alu; MemoryData_MEM = md; PCPlus4_MEM = pc;
    endtask

    task automatic set_rand();
        set_in(($urandom_range(0, 9) != 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        set_in(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");

        reset = 1'b1;
        // Three valid instructions
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 0, 5'(i + 1), $urandom, $urandom, $urandom);
            tick("run3");
        end
        check("run3.cnt_abs", RetiredCount, 32'd2);

        // Asynchronous reset between edges
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst.cnt0", RetiredCount, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Load path
        set_in(1, 1, 1, 0, 5'd8, 32'h1001_0004, 32'h1234_5678, 32'h0);
        tick("load");
        check("load.rw_abs", {31'd0, RegWrite_WB}, 32'd1);
        check("load.wr_abs", {27'd0, WriteRegister_WB}, 32'd8);
        check("load.wd_abs", WriteData_WB, 32'h1234_5678);

        // Jal beats MemtoReg
        set_in(1, 1, 1, 1, 5'd31, 32'h1111_1111, 32'h2222_2222, 32'h0040_0010);
        tick("jal");
        check("jal.wd_abs", WriteData_WB, 32'h0040_0010);
        check("jal.wr_abs", {27'd0, WriteRegister_WB}, 32'd31);

        // $zero guard
        set_in(1, 1, 0, 0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        tick("zero");
        check("zero.rw_abs", {31'd0, RegWrite_WB}, 32'd0);
        check("zero.valid_abs", {31'd0, Valid_WB}, 32'd1);
        saved_cnt = RetiredCount;
        set_in(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
        tick("zero_ret");
        check("zero_ret.cnt_inc", RetiredCount, saved_cnt + 32'd1);

        // Valid instruction then 3 stalled cycles with changing inputs
        set_in(1, 1, 0, 0, 5'd9, 32'hCAFE_0009, 32'h0, 32'h0);
        tick("pre_stall");
        saved_cnt = RetiredCount;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand();
            tick("stall");
        end
        check("stall.wd_abs", WriteData_WB, 32'hCAFE_0009);
        check("stall.cnt_hold", RetiredCount, saved_cnt);

        // Stall and Flush together: flush wins
        Flush = 1'b1;
        set_in(1, 1, 0, 0, 5'd10, 32'h5555_AAAA, 32'h0, 32'h0);
        tick("stall_flush");
        check("stall_flush.valid_abs", {31'd0, Valid_WB}, 32'd0);
        check("stall_flush.rw_abs", {31'd0, RegWrite_WB}, 32'd0);
        check("stall_flush.cnt_hold", RetiredCount, saved_cnt);
        Stall = 1'b0; Flush = 1'b0;

        // Counter wrap via deposit
        dut.retired_q <= 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 1, 0, 0, 5'(i + 3), $urandom, $urandom, $urandom);
            tick("wrap");
        end
        check("wrap.cnt_abs", RetiredCount, 32'h0000_0001);

        // Random traffic with occasional stall/flush
        for (int i = 0; i < 300; i++) begin
            set_rand();
            Stall = ($urandom_range(0, 4) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            tick("rand");
        end
        Stall = 1'b0; Flush = 1'b0;

        // Reset during a stall
        Stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("rst_in_stall");
        @(negedge clk);
        reset = 1'b1; Stall = 1'b0;
        set_in(1, 1, 0, 0, 5'd4, 32'h0BAD_F00D, 32'h0, 32'h0);
        tick("post_rst");
        check("post_rst.wd_abs", WriteData_WB, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
